// File: rtl/peak_pkg.sv
// Shared FSM state type and PeakY width-extension helper for the top-K peak finder.
package peak_pkg;

  typedef enum logic [2:0] {IDLE, RUN, FLUSH, DRAIN, DONE} state_t;

  localparam int SUM_W = 34;

  // Three samples of up to 32 bits each, sign-extended before the add so the sum cannot wrap.
  function automatic logic signed [SUM_W-1:0] y_sum3(input logic signed [31:0] a,
                                                     input logic signed [31:0] b,
                                                     input logic signed [31:0] c);
    return SUM_W'(a) + SUM_W'(b) + SUM_W'(c);
  endfunction

endpackage

// File: rtl/peak_topk_table.sv
// Sorted top-K peak table: descending by y, equal y keeps the earlier entry higher.
// Single-cycle parallel compare and shift-insert, synchronous clear, indexed read.
module peak_topk_table #(
  parameter int K  = 4,
  parameter int AW = 12,
  parameter int YW = 10,
  localparam int IW = (K > 1) ? $clog2(K) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 ins,
  input  logic        [AW-1:0] ins_x,
  input  logic signed [YW-1:0] ins_y,
  input  logic        [IW-1:0] rd_idx,
  output logic                 rd_valid,
  output logic        [AW-1:0] rd_x,
  output logic signed [YW-1:0] rd_y
);
  logic [K-1:0]         valid_q, valid_d, ge, above;
  logic [AW-1:0]        x_q [K];
  logic [AW-1:0]        x_d [K];
  logic signed [YW-1:0] y_q [K];
  logic signed [YW-1:0] y_d [K];

  // Valid entries are contiguous from the top, so ge is a thermometer code.
  always_comb begin
    ge    = '0;
    above = '0;
    for (int i = 0; i < K; i++) ge[i] = valid_q[i] && (y_q[i] >= ins_y);
    above[0] = 1'b1;
    for (int i = 1; i < K; i++) above[i] = ge[i-1];
  end

  always_comb begin
    valid_d = valid_q;
    x_d     = x_q;
    y_d     = y_q;
    if (ins) begin
      for (int i = 0; i < K; i++) begin
        if (!ge[i] && above[i]) begin
          valid_d[i] = 1'b1;
          x_d[i]     = ins_x;
          y_d[i]     = ins_y;
        end
      end
      for (int i = 1; i < K; i++) begin
        if (!ge[i] && !above[i]) begin
          valid_d[i] = valid_q[i-1];
          x_d[i]     = x_q[i-1];
          y_d[i]     = y_q[i-1];
        end
      end
    end
    if (clear) valid_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < K; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < K; i++) begin
        x_q[i] <= x_d[i];
        y_q[i] <= y_d[i];
      end
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_x     = x_q[rd_idx];
  assign rd_y     = y_q[rd_idx];

endmodule

// File: rtl/peak_find_topk.sv
// Streaming peak finder: thresholded local maxima with minimum separation, the K strongest
// kept in a sorted table and reported in rank order after the frame.
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | accepting FRAME_LEN samples
//   FLUSH | final candidate evaluation
//   DRAIN | one ranked peak per cycle
//   DONE  | pk_done strobe
module peak_find_topk
  import peak_pkg::*;
#(
  parameter int DW        = 8,
  parameter int AW        = 12,
  parameter int FRAME_LEN = 1000,
  parameter int K         = 4,
  localparam int YW = DW + 2,
  localparam int IW = (K > 1) ? $clog2(K) : 1,
  localparam int CW = $clog2(K + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic signed [DW-1:0] thresh,
  input  logic        [AW-1:0] min_dist,
  output logic                 rd,
  output logic        [AW-1:0] addr_out,
  input  logic                 rdy,
  input  logic signed [DW-1:0] FreqIn,
  output logic                 PkClk,
  output logic        [AW-1:0] PeakX,
  output logic signed [YW-1:0] PeakY,
  output logic        [IW-1:0] pk_idx,
  output logic        [CW-1:0] pk_cnt,
  output logic                 pk_done,
  output logic                 busy
);
  localparam logic [AW-1:0] LAST = AW'(FRAME_LEN - 1);

  state_t               state_q, state_d;
  logic signed [DW-1:0] thr_q, win0_q, win1_q, win2_q;
  logic        [AW-1:0] dist_q, last_cand_q;
  logic        [1:0]    fill_q;
  logic                 have_last_q, chk_q;
  logic        [CW-1:0] rd_ptr_q;

  logic                 go, acc, is_cand, keep, more;
  logic        [AW-1:0] cand_x;
  logic signed [YW-1:0] cand_y;
  logic                 tbl_valid;
  logic        [AW-1:0] tbl_x;
  logic signed [YW-1:0] tbl_y;

  assign go      = (state_q == IDLE) && start;
  assign acc     = (state_q == RUN) && rdy;
  // chk_q marks the cycle after an accept: the window is centred on sample addr_out-2.
  assign cand_x  = addr_out - AW'(2);
  assign cand_y  = YW'(y_sum3(32'(win2_q), 32'(win1_q), 32'(win0_q)));
  assign is_cand = chk_q && (fill_q == 2'd3) && (win1_q > win2_q) &&
                   (win1_q >= win0_q) && (win1_q > thr_q);
  assign keep    = is_cand &&
                   !(have_last_q && (dist_q != '0) && ((cand_x - last_cand_q) < dist_q));
  assign more    = (rd_ptr_q < CW'(K)) && tbl_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (acc && (addr_out == LAST)) state_d = FLUSH;
      FLUSH:   state_d = DRAIN;
      DRAIN:   if (!more) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_out    <= '0;
      thr_q       <= '0;
      dist_q      <= '0;
      last_cand_q <= '0;
      have_last_q <= 1'b0;
      win0_q      <= '0;
      win1_q      <= '0;
      win2_q      <= '0;
      fill_q      <= '0;
      chk_q       <= 1'b0;
      rd_ptr_q    <= '0;
      PkClk       <= 1'b0;
      PeakX       <= '0;
      PeakY       <= '0;
      pk_idx      <= '0;
      pk_cnt      <= '0;
    end else begin
      PkClk <= 1'b0;
      chk_q <= acc;
      if (go) begin
        addr_out    <= '0;
        thr_q       <= thresh;
        dist_q      <= min_dist;
        have_last_q <= 1'b0;
        fill_q      <= '0;
      end
      if (acc) begin
        win2_q   <= win1_q;
        win1_q   <= win0_q;
        win0_q   <= FreqIn;
        addr_out <= addr_out + AW'(1);
        if (fill_q != 2'd3) fill_q <= fill_q + 2'd1;
      end
      if (keep) begin
        last_cand_q <= cand_x;
        have_last_q <= 1'b1;
      end
      if (state_q == FLUSH) rd_ptr_q <= '0;
      if (state_q == DRAIN) begin
        if (more) begin
          PkClk    <= 1'b1;
          PeakX    <= tbl_x;
          PeakY    <= tbl_y;
          pk_idx   <= rd_ptr_q[IW-1:0];
          rd_ptr_q <= rd_ptr_q + CW'(1);
        end else begin
          pk_cnt <= rd_ptr_q;
        end
      end
    end
  end

  peak_topk_table #(.K(K), .AW(AW), .YW(YW)) u_table (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (go),
    .ins      (keep),
    .ins_x    (cand_x),
    .ins_y    (cand_y),
    .rd_idx   (rd_ptr_q[IW-1:0]),
    .rd_valid (tbl_valid),
    .rd_x     (tbl_x),
    .rd_y     (tbl_y)
  );

  assign rd      = (state_q == RUN);
  assign busy    = (state_q != IDLE);
  assign pk_done = (state_q == DONE);

endmodule

// File: tb/tb_peak_find_topk.sv
// Directed bench for peak_find_topk: a K=4 and a K=2 instance share one 16-sample stimulus.
module tb_peak_find_topk;

  logic clk = 1'b0;
  logic rst_n, start, rdy;
  logic signed [7:0] thresh, freq_in;
  logic [11:0] min_dist;

  logic rd_a, pkclk_a, done_a, busy_a;
  logic [11:0] addr_a, peakx_a;
  logic signed [9:0] peaky_a;
  logic [1:0] idx_a;
  logic [2:0] cnt_a;

  logic rd_b, pkclk_b, done_b, busy_b;
  logic [11:0] addr_b, peakx_b;
  logic signed [9:0] peaky_b;
  logic [0:0] idx_b;
  logic [1:0] cnt_b;

  int checks = 0;
  int failures = 0;
  int frame [16];
  int n_a, n_b, done_k_a, done_k_b, cnt_got_a, cnt_got_b;
  int gx_a [8], gy_a [8], gi_a [8], gk_a [8];
  int gx_b [8], gy_b [8], gi_b [8], gk_b [8];

  always #5 clk = ~clk;

  peak_find_topk #(.DW(8), .AW(12), .FRAME_LEN(16), .K(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .thresh(thresh), .min_dist(min_dist),
    .rd(rd_a), .addr_out(addr_a), .rdy(rdy), .FreqIn(freq_in), .PkClk(pkclk_a),
    .PeakX(peakx_a), .PeakY(peaky_a), .pk_idx(idx_a), .pk_cnt(cnt_a),
    .pk_done(done_a), .busy(busy_a));

  peak_find_topk #(.DW(8), .AW(12), .FRAME_LEN(16), .K(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .thresh(thresh), .min_dist(min_dist),
    .rd(rd_b), .addr_out(addr_b), .rdy(rdy), .FreqIn(freq_in), .PkClk(pkclk_b),
    .PeakX(peakx_b), .PeakY(peaky_b), .pk_idx(idx_b), .pk_cnt(cnt_b),
    .pk_done(done_b), .busy(busy_b));

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_start(input int th, input int md);
    @(negedge clk);
    check("idle_busy", busy_a, 0);
    thresh   = 8'(th);
    min_dist = 12'(md);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", busy_a, 1);
    check("start_rd", rd_a, 1);
    check("start_addr", addr_a, 0);
  endtask

  task automatic feed(input int gaps);
    for (int i = 0; i < 16; i++) begin
      rdy     = 1'b1;
      freq_in = 8'(frame[i]);
      @(negedge clk);
      rdy     = 1'b0;
      freq_in = 8'sd127;
      if (i < 15) begin
        for (int g = 0; g < gaps; g++) begin
          @(negedge clk);
          check("stall_addr", addr_a, i + 1);
        end
      end
    end
    check("flush_rd", rd_a, 0);
    check("flush_busy", busy_a, 1);
  endtask

  // k counts negedges after the one following the last accepted sample.
  task automatic collect(input bit hold_rdy, input bit poke);
    bit da, db;
    n_a = 0; n_b = 0; done_k_a = -1; done_k_b = -1; da = 0; db = 0;
    rdy = hold_rdy;
    freq_in = 8'sd127;
    for (int k = 1; k <= 12 && !(da && db); k++) begin
      @(negedge clk);
      start = 1'b0;
      if (pkclk_a && n_a < 8) begin
        gx_a[n_a] = int'(peakx_a); gy_a[n_a] = int'(peaky_a);
        gi_a[n_a] = int'(idx_a);   gk_a[n_a] = k;
        n_a++;
        if (poke && n_a == 1) start = 1'b1;
      end
      if (pkclk_b && n_b < 8) begin
        gx_b[n_b] = int'(peakx_b); gy_b[n_b] = int'(peaky_b);
        gi_b[n_b] = int'(idx_b);   gk_b[n_b] = k;
        n_b++;
      end
      if (done_a && !da) begin da = 1; done_k_a = k; cnt_got_a = int'(cnt_a); end
      if (done_b && !db) begin db = 1; done_k_b = k; cnt_got_b = int'(cnt_b); end
    end
    rdy = 1'b0;
    start = 1'b0;
  endtask

  task automatic verify(input string tag, input bit is_b, input int n,
                        input int x0, input int y0, input int x1, input int y1,
                        input int x2, input int y2);
    int ex [3];
    int ey [3];
    int gx [8], gy [8], gi [8], gk [8];
    int gn, gd, gc;
    ex[0] = x0; ex[1] = x1; ex[2] = x2;
    ey[0] = y0; ey[1] = y1; ey[2] = y2;
    for (int r = 0; r < 8; r++) begin
      gx[r] = is_b ? gx_b[r] : gx_a[r];
      gy[r] = is_b ? gy_b[r] : gy_a[r];
      gi[r] = is_b ? gi_b[r] : gi_a[r];
      gk[r] = is_b ? gk_b[r] : gk_a[r];
    end
    gn = is_b ? n_b : n_a;
    gd = is_b ? done_k_b : done_k_a;
    gc = is_b ? cnt_got_b : cnt_got_a;
    check($sformatf("%s_pk_cnt", tag), gc, n);
    check($sformatf("%s_pulses", tag), gn, n);
    check($sformatf("%s_done_cycle", tag), gd, 2 + n);
    for (int r = 0; r < n && r < gn; r++) begin
      check($sformatf("%s_x%0d", tag, r), gx[r], ex[r]);
      check($sformatf("%s_y%0d", tag, r), gy[r], ey[r]);
      check($sformatf("%s_idx%0d", tag, r), gi[r], r);
      check($sformatf("%s_pulse_cycle%0d", tag, r), gk[r], 2 + r);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; rdy = 1'b0;
    thresh = '0; min_dist = '0; freq_in = '0;
    repeat (2) @(negedge clk);
    check("rst_rd", rd_a, 0);
    check("rst_addr", addr_a, 0);
    check("rst_pkclk", pkclk_a, 0);
    check("rst_peakx", peakx_a, 0);
    check("rst_peaky", peaky_a, 0);
    check("rst_pk_idx", idx_a, 0);
    check("rst_pk_cnt", cnt_a, 0);
    check("rst_pk_done", done_a, 0);
    check("rst_busy", busy_a, 0);
    rst_n = 1'b1;

    // Basic frame; rdy held high with junk after the frame must be ignored.
    frame = '{0, 10, 50, 20, 0, 0, 0, 5, 30, 5, 0, 0, 20, 70, 20, 0};
    do_start(10, 0); feed(0); collect(1'b1, 1'b0);
    verify("basic_k4", 1'b0, 3, 13, 110, 2, 80, 8, 40);
    verify("overflow_k2", 1'b1, 2, 13, 110, 2, 80, 0, 0);

    // Equal y: earlier index ranks higher; start pulsed during DRAIN.
    frame = '{0, 10, 50, 20, 0, 0, 0, 10, 50, 20, 0, 0, 0, 0, 0, 0};
    do_start(10, 0); feed(0); collect(1'b0, 1'b1);
    verify("tie_k4", 1'b0, 2, 2, 80, 8, 80, 0, 0);
    verify("tie_k2", 1'b1, 2, 2, 80, 8, 80, 0, 0);

    // Edge samples, plateau, and a peak equal to the threshold.
    frame = '{100, 0, 0, 40, 40, 0, 0, 10, 0, 0, 0, 0, 0, 0, 0, 90};
    do_start(10, 0); feed(0); collect(1'b0, 1'b0);
    verify("edge_k4", 1'b0, 1, 3, 80, 0, 0, 0, 0);
    verify("edge_k2", 1'b1, 1, 3, 80, 0, 0, 0, 0);

    // Separation: 7 is too close to 5, 9 is measured against 5.
    frame = '{0, 0, 0, 0, 0, 30, 0, 20, 0, 15, 0, 0, 0, 0, 0, 0};
    do_start(10, 4); feed(0); collect(1'b0, 1'b0);
    verify("sep4_k4", 1'b0, 2, 5, 30, 9, 15, 0, 0);
    verify("sep4_k2", 1'b1, 2, 5, 30, 9, 15, 0, 0);
    do_start(10, 0); feed(0); collect(1'b0, 1'b0);
    verify("sep0_k4", 1'b0, 3, 5, 30, 7, 20, 9, 15);
    verify("sep0_k2", 1'b1, 2, 5, 30, 7, 20, 0, 0);

    // Stalls: rdy pattern 1-0-0-1.
    frame = '{0, 10, 50, 20, 0, 0, 0, 5, 30, 5, 0, 0, 20, 70, 20, 0};
    do_start(10, 0); feed(2); collect(1'b0, 1'b0);
    verify("stall_k4", 1'b0, 3, 13, 110, 2, 80, 8, 40);

    // Flat zero frame: no peaks, pk_done two cycles after the last sample.
    frame = '{default: 0};
    do_start(10, 0); feed(0); collect(1'b0, 1'b0);
    verify("zero_k4", 1'b0, 0, 0, 0, 0, 0, 0, 0);
    verify("zero_k2", 1'b1, 0, 0, 0, 0, 0, 0, 0);

    // Asynchronous reset mid-RUN, then a clean restart.
    frame = '{0, 10, 50, 20, 0, 0, 0, 5, 30, 5, 0, 0, 20, 70, 20, 0};
    do_start(10, 0);
    for (int i = 0; i < 5; i++) begin
      rdy = 1'b1; freq_in = 8'(frame[i]);
      @(negedge clk);
    end
    rdy = 1'b0;
    check("pre_rst_addr", addr_a, 5);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_rd", rd_a, 0);
    check("async_rst_busy", busy_a, 0);
    check("async_rst_pkclk", pkclk_a, 0);
    check("async_rst_pk_done", done_a, 0);
    check("async_rst_addr", addr_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_start(10, 0); feed(0); collect(1'b0, 1'b0);
    verify("restart_k4", 1'b0, 3, 13, 110, 2, 80, 8, 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
